// File: rtl/result_display_if.sv
// Result display bus: groups the load/capture inputs and the display/result
// outputs of result_display.
//   load_done  : one-cycle pulse, new image registered into the network
//   img_index  : image number (0..999, larger values saturate)
//   ntk_out    : one-hot network classification
//   an/seg/dp  : active-low 7-segment drive (an[3] leftmost, seg = gfedcba)
//   pred_valid : prediction and BCD index are stable
//   pred_digit : decoded prediction, 4'hF on error
//   err        : ntk_out was not one-hot at capture
interface result_display_if;
  logic       load_done;
  logic [9:0] img_index;
  logic [9:0] ntk_out;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       pred_valid;
  logic [3:0] pred_digit;
  logic       err;

  // master drives the image/network side, slave is the display block
  modport master (
    output load_done, img_index, ntk_out,
    input  an, seg, dp, pred_valid, pred_digit, err
  );
  modport slave (
    input  load_done, img_index, ntk_out,
    output an, seg, dp, pred_valid, pred_digit, err
  );
endinterface

// File: rtl/result_display.sv
// result_display: waits SETTLE_CYCLES after load_done, captures the one-hot
// network output, converts the latched image index to BCD (shift-add-3, one
// bit per cycle) and multiplexes prediction + index onto four 7-seg digits.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : result_display_if.slave (load/capture inputs, display/results)
module result_display #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SCAN_DIV      = 65536,
  parameter int SCAN_WIDTH    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  result_display_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, SHOW} state_e;

  localparam logic [7:0]            SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [SCAN_WIDTH-1:0] SCAN_LAST   = SCAN_WIDTH'(SCAN_DIV - 1);
  localparam logic [6:0]            SEG_DASH    = 7'b0111111;

  state_e      state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [9:0]  bin_q, bin_d;       // latched index, shifted out MSB first
  logic [11:0] bcd_q, bcd_d;       // {hundreds, tens, ones}
  logic [3:0]  pdig_q, pdig_d;
  logic        err_q, err_d;
  logic        pvld_q, pvld_d;

  logic [SCAN_WIDTH-1:0] scan_q, scan_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  // one-hot decode of the network output
  logic [3:0] hot_cnt, hot_idx;
  always_comb begin
    hot_cnt = '0;
    hot_idx = '0;
    for (int k = 0; k < 10; k++) begin
      if (bus.ntk_out[k]) begin
        hot_cnt = hot_cnt + 4'd1;
        hot_idx = 4'(k);
      end
    end
  end

  // double-dabble correction applied before each shift
  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int n = 0; n < 3; n++)
      if (r[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  logic [11:0] bcd_adj;
  assign bcd_adj = add3(bcd_q);

  // FSM next state + datapath
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    bitcnt_d = bitcnt_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    pdig_d   = pdig_q;
    err_d    = err_q;
    pvld_d   = pvld_q;
    if (bus.load_done) begin
      // a new load always wins, even mid-conversion
      state_d  = SETTLE;
      settle_d = '0;
      bin_d    = (bus.img_index > 10'd999) ? 10'd999 : bus.img_index;
      pvld_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            if (hot_cnt == 4'd1) begin
              err_d  = 1'b0;
              pdig_d = hot_idx;
            end else begin
              err_d  = 1'b1;
              pdig_d = 4'hF;
            end
            bcd_d    = '0;
            bitcnt_d = '0;
            state_d  = CONVERT;
          end else begin
            settle_d = settle_q + 8'd1;
          end
        end
        CONVERT: begin
          bcd_d    = {bcd_adj[10:0], bin_q[9]};
          bin_d    = {bin_q[8:0], 1'b0};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) begin
            state_d = SHOW;
            pvld_d  = 1'b1;
          end
        end
        SHOW: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // digit scan + display encoding
  always_comb begin
    logic [3:0] dval;
    logic       dash;
    dval  = '0;
    dash  = 1'b1;
    scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_WIDTH'(1);
    sel_d  = (scan_q == SCAN_LAST) ? sel_q + 2'd1 : sel_q;
    if (pvld_q) begin
      dash = 1'b0;
      unique case (sel_q)
        2'd3: begin dval = pdig_q; dash = err_q; end
        2'd2: dval = bcd_q[11:8];
        2'd1: dval = bcd_q[7:4];
        default: dval = bcd_q[3:0];
      endcase
    end
    seg_d = dash ? SEG_DASH : seg7(dval);
    an_d  = ~(4'b0001 << sel_q);
    dp_d  = ~((sel_q == 2'd3) && err_q && pvld_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      bitcnt_q <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      pdig_q   <= '0;
      err_q    <= 1'b0;
      pvld_q   <= 1'b0;
      scan_q   <= '0;
      sel_q    <= '0;
      an_q     <= 4'b1110;
      seg_q    <= SEG_DASH;
      dp_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      bitcnt_q <= bitcnt_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      pdig_q   <= pdig_d;
      err_q    <= err_d;
      pvld_q   <= pvld_d;
      scan_q   <= scan_d;
      sel_q    <= sel_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.pred_valid = pvld_q;
  assign bus.pred_digit = pdig_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display (SETTLE_CYCLES=4, SCAN_DIV=4).
module tb_result_display;
  localparam int S   = 4;
  localparam int LAT = S + 10;
  localparam logic [6:0] DASH = 7'b0111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  result_display_if bus();

  result_display #(.SETTLE_CYCLES(S), .SCAN_DIV(4), .SCAN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_digit(input logic [9:0] n);
    if ($countones(n) == 1) return 4'($clog2(n));
    return 4'hF;
  endfunction

  function automatic int m_idx(input int img);
    return (img > 999) ? 999 : img;
  endfunction

  function automatic logic [6:0] m_seg(input int pos, input logic [3:0] pd, input int idx);
    case (pos)
      3: return (pd > 4'd9) ? DASH : segtab[pd];
      2: return segtab[idx / 100];
      1: return segtab[(idx / 10) % 10];
      default: return segtab[idx % 10];
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [9:0] img, input logic [9:0] ntk);
    bus.img_index = img;
    bus.ntk_out   = ntk;
    bus.load_done = 1'b1;
    step();
    bus.load_done = 1'b0;
  endtask

  // edges after the load edge until pred_valid is seen (40 = timed out)
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.pred_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  // record what each anode position shows over a full scan period
  task automatic scan_display(output logic [3:0][6:0] segs, output logic [3:0] dps,
                              output logic bad);
    segs = 'x;
    dps  = 'x;
    bad  = 1'b0;
    repeat (20) begin
      step();
      case (bus.an)
        4'b1110: begin segs[0] = bus.seg; dps[0] = bus.dp; end
        4'b1101: begin segs[1] = bus.seg; dps[1] = bus.dp; end
        4'b1011: begin segs[2] = bus.seg; dps[2] = bus.dp; end
        4'b0111: begin segs[3] = bus.seg; dps[3] = bus.dp; end
        default: bad = 1'b1;
      endcase
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    n_checks++; if (bus.an !== 4'b1110) begin n_fail++; $display("FAIL rst_an: got %b want %b", bus.an, 4'b1110); end
    n_checks++; if (bus.seg !== DASH) begin n_fail++; $display("FAIL rst_seg: got %b want %b", bus.seg, DASH); end
    n_checks++; if (bus.dp !== 1'b1) begin n_fail++; $display("FAIL rst_dp: got %b want 1", bus.dp); end
    n_checks++; if (bus.pred_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.pred_valid); end
    n_checks++; if (bus.pred_digit !== 4'h0) begin n_fail++; $display("FAIL rst_digit: got %h want 0", bus.pred_digit); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.err); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step();
    n_checks++; if (bus.pred_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", bus.pred_valid); end
  endtask

  task automatic test_basic();
    int lat;
    logic [3:0][6:0] segs; logic [3:0] dps; logic bad;
    pulse_load(10'd437, 10'b0010000000);
    wait_valid(lat);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (bus.pred_digit !== 4'd7) begin n_fail++; $display("FAIL basic_digit: got %h want 7", bus.pred_digit); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", bus.err); end
    scan_display(segs, dps, bad);
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (segs[p] !== m_seg(p, 4'd7, 437)) begin
        n_fail++; $display("FAIL basic_seg%0d: got %b want %b", p, segs[p], m_seg(p, 4'd7, 437));
      end
    end
    n_checks++; if (dps !== 4'b1111 || bad) begin n_fail++; $display("FAIL basic_dp_an: dp %b bad %b want 1111/0", dps, bad); end
  endtask

  task automatic test_err();
    int lat;
    logic [3:0][6:0] segs; logic [3:0] dps; logic bad;
    logic [9:0] pats [2] = '{10'b0000000000, 10'b0000100100};
    int imgs [2] = '{12, 580};
    for (int t = 0; t < 2; t++) begin
      pulse_load(10'(imgs[t]), pats[t]);
      wait_valid(lat);
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL err%0d_latency: got %0d want %0d", t, lat, LAT); end
      n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err%0d_flag: got %b want 1", t, bus.err); end
      n_checks++; if (bus.pred_digit !== 4'hF) begin n_fail++; $display("FAIL err%0d_digit: got %h want f", t, bus.pred_digit); end
      scan_display(segs, dps, bad);
      n_checks++; if (segs[3] !== DASH) begin n_fail++; $display("FAIL err%0d_dash: got %b want %b", t, segs[3], DASH); end
      n_checks++; if (dps !== 4'b0111) begin n_fail++; $display("FAIL err%0d_dp: got %b want 0111", t, dps); end
      for (int p = 0; p < 3; p++) begin
        n_checks++;
        if (segs[p] !== m_seg(p, 4'hF, imgs[t])) begin
          n_fail++; $display("FAIL err%0d_seg%0d: got %b want %b", t, p, segs[p], m_seg(p, 4'hF, imgs[t]));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic early;
    logic [3:0][6:0] segs; logic [3:0] dps; logic bad;
    early = 1'b0;
    pulse_load(10'd123, 10'b0000000100);
    // second load lands on the edge 3 cycles into CONVERT
    repeat (6) begin step(); if (bus.pred_valid) early = 1'b1; end
    pulse_load(10'd999, 10'b0000100000);
    wait_valid(lat);
    n_checks++; if (early) begin n_fail++; $display("FAIL b2b_first_valid: got 1 want 0"); end
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (bus.pred_digit !== 4'd5) begin n_fail++; $display("FAIL b2b_digit: got %h want 5", bus.pred_digit); end
    scan_display(segs, dps, bad);
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (segs[p] !== m_seg(p, 4'd5, 999)) begin
        n_fail++; $display("FAIL b2b_seg%0d: got %b want %b", p, segs[p], m_seg(p, 4'd5, 999));
      end
    end
  endtask

  task automatic test_saturate();
    int lat;
    logic [3:0][6:0] segs; logic [3:0] dps; logic bad;
    pulse_load(10'd1023, 10'b0000000001);
    wait_valid(lat);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL sat_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (bus.pred_digit !== 4'd0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL sat_digit: got %h/%b want 0/0", bus.pred_digit, bus.err); end
    scan_display(segs, dps, bad);
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (segs[p] !== m_seg(p, 4'd0, 999)) begin
        n_fail++; $display("FAIL sat_seg%0d: got %b want %b", p, segs[p], m_seg(p, 4'd0, 999));
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] prev, cur;
    int run, bad;
    logic seen;
    prev = bus.an; run = 0; bad = 0; seen = 1'b0;
    repeat (48) begin
      step();
      cur = bus.an;
      if ($countones(~cur) != 1) bad++;
      if (cur == prev) run++;
      else begin
        if (seen) begin
          n_checks++; if (run != 4) begin n_fail++; $display("FAIL scan_hold: got %0d want 4", run); end
        end
        n_checks++;
        if (cur !== {prev[2:0], prev[3]}) begin
          n_fail++; $display("FAIL scan_order: got %b want %b", cur, {prev[2:0], prev[3]});
        end
        run = 1; seen = 1'b1;
      end
      prev = cur;
    end
    n_checks++; if (bad != 0 || !seen) begin n_fail++; $display("FAIL scan_onehot: bad %0d seen %b want 0/1", bad, seen); end
  endtask

  task automatic test_random();
    int lat, img, idx;
    logic [9:0] ntk;
    logic [3:0] pd;
    logic [3:0][6:0] segs; logic [3:0] dps; logic bad;
    for (int it = 0; it < 24; it++) begin
      img = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) == 0) ntk = 10'($urandom);
      else ntk = 10'b1 << $urandom_range(0, 9);
      pd  = m_digit(ntk);
      idx = m_idx(img);
      pulse_load(10'(img), ntk);
      // inputs wander outside the latch/capture edges
      lat = 0;
      while (!bus.pred_valid && lat < 40) begin
        bus.img_index = 10'($urandom);
        if (lat >= S) bus.ntk_out = 10'($urandom);
        step();
        lat++;
      end
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, LAT); end
      n_checks++; if (bus.pred_digit !== pd) begin n_fail++; $display("FAIL rnd%0d_digit: got %h want %h", it, bus.pred_digit, pd); end
      n_checks++; if (bus.err !== (pd == 4'hF)) begin n_fail++; $display("FAIL rnd%0d_err: got %b want %b", it, bus.err, pd == 4'hF); end
      scan_display(segs, dps, bad);
      for (int p = 0; p < 4; p++) begin
        n_checks++;
        if (segs[p] !== m_seg(p, pd, idx)) begin
          n_fail++; $display("FAIL rnd%0d_seg%0d: got %b want %b (img %0d ntk %b)", it, p, segs[p], m_seg(p, pd, idx), img, ntk);
        end
      end
      n_checks++;
      if (dps !== {(pd != 4'hF), 3'b111} || bad) begin
        n_fail++; $display("FAIL rnd%0d_dp: got %b bad %b want %b", it, dps, bad, {(pd != 4'hF), 3'b111});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic rose;
    logic [3:0][6:0] segs; logic [3:0] dps; logic bad;
    pulse_load(10'd321, 10'b0000001000);
    repeat (5) step();
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.an !== 4'b1110 || bus.seg !== DASH || bus.dp !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_disp: got %b/%b/%b want 1110/%b/1", bus.an, bus.seg, bus.dp, DASH); end
    n_checks++; if (bus.pred_valid !== 1'b0 || bus.pred_digit !== 4'd0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_res: got %b/%h/%b want 0/0/0", bus.pred_valid, bus.pred_digit, bus.err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rose = 1'b0;
    repeat (30) begin step(); if (bus.pred_valid) rose = 1'b1; end
    n_checks++; if (rose) begin n_fail++; $display("FAIL mid_rst_idle: got valid 1 want 0"); end
    scan_display(segs, dps, bad);
    n_checks++; if (segs !== {4{DASH}} || dps !== 4'b1111) begin
      n_fail++; $display("FAIL mid_rst_dash: got %h/%b want all dash/1111", segs, dps); end
  endtask

  initial begin
    bus.load_done = 1'b0;
    bus.img_index = '0;
    bus.ntk_out   = '0;
    test_reset();
    test_basic();
    test_err();
    test_back_to_back();
    test_saturate();
    test_scan();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: cycles from load_done to ntk_out sampling; legal range 1..255.
REQ-002 SHALL have parameter SCAN_DIV, default 65536: clk cycles per display digit.
REQ-003 SHALL have parameter SCAN_WIDTH, default 16: scan counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load_done  input  1  single-cycle pulse: new image registered into network.
REQ-007 SHALL have port img_index  input  10  image number, 0..999.
REQ-008 SHALL have port ntk_out  input  10  network classification, one-hot, bit k = digit k.
REQ-009 SHALL have port an  output  4  7-seg anodes, active-low, an[3] leftmost.
REQ-010 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp  output  1  decimal point, active-low.
REQ-012 SHALL have port pred_valid  output  1  prediction and BCD index stable.
REQ-013 SHALL have port pred_digit  output  4  decoded prediction, 0..9, or 4'hF on error.
REQ-014 SHALL have port err  output  1  ntk_out was not one-hot at capture.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, CONVERT, SHOW.
REQ-016 SHALL, on load_done=1 at edge E0 in any state: enter SETTLE, clear settle count, latch img_index (values >999 saturate to 999), drive pred_valid=0; abandon any in-progress conversion.
REQ-017 SHALL sample ntk_out at edge E0+SETTLE_CYCLES, absent a newer load_done, and enter CONVERT.
REQ-018 SHALL, at capture, set err=0 and pred_digit=index of the set bit if exactly one bit is set; otherwise set err=1 and pred_digit=4'hF (covers zero and multiple bits).
REQ-019 SHALL convert the latched index to three BCD digits (hundreds, tens, ones) by shift-add-3, one bit per cycle, 10 cycles in CONVERT.
REQ-020 SHALL enter SHOW with pred_valid=1 at edge E0+SETTLE_CYCLES+10, and hold SHOW and all results until the next load_done.
REQ-021 SHALL ignore ntk_out and img_index changes outside the capture and latch edges.
REQ-022 SHALL run a free-running scan counter wrapping at SCAN_DIV-1 and advance the digit select 0->1->2->3->0 on each wrap.
REQ-023 SHALL drive exactly one an bit low at all times: an[i] low when select=i.
REQ-024 SHALL, with pred_valid=1, show digit 3 = pred_digit (dash if err) and digits 2..0 = hundreds/tens/ones of the index, leading zeros shown.
REQ-025 SHALL show a dash on all four digits while pred_valid=0.
REQ-026 SHALL use segment encodings (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111.
REQ-027 SHALL drive dp=0 only when select=3 and err=1 and pred_valid=1; otherwise dp=1.
REQ-028 SHALL register an, seg and dp, so display outputs lag the select by one cycle.

Reset
REQ-029 SHALL, while rst_n=0 and independent of clk: state=IDLE, pred_valid=0, pred_digit=0, err=0, BCD digits=0, scan counter=0, select=0, an=4'b1110, seg=7'b0111111, dp=1.
REQ-030 SHALL, when rst_n falls mid-SETTLE or mid-CONVERT, discard the operation; after release remain IDLE until load_done.

Verification
REQ-031 SHALL cover: reset, then load_done with img_index=437 and ntk_out=10'b0010000000 (S=4) -> pred_valid rises after edge E0+14; pred_digit=7; err=0; digits show 7,4,3,7.
REQ-032 SHALL cover: ntk_out=10'b0000000000 at capture, then 10'b0000100100 on a second load -> err=1 and pred_digit=4'hF both times; digit 3 shows dash with dp=0.
REQ-033 SHALL cover: second load_done 3 cycles into CONVERT with img_index=999 -> first result never flagged valid; pred_valid rises 14 cycles after the second pulse; digits show 9,9,9.
REQ-034 SHALL cover: img_index=1023 with ntk_out bit 0 set -> index shows 999; pred_digit=0.
REQ-035 SHALL cover: SCAN_DIV=4 -> an sequence 1110,1101,1011,0111, each held 4 cycles, repeating; never two bits low.
REQ-036 SHALL cover: rst_n low at edge E0+6 -> immediate reset values per REQ-029; FSM stays IDLE after release.
